// File: rtl/interrupt_dispatch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_dispatch_sequencer
//  Description : Owns IME (EI delay, DI, RETI), selects the highest-priority
//                pending interrupt and runs the dispatch sequence: wait,
//                push PC high/low via handshake, load vector, clear IF bit.
//                Also provides the combinational HALT wake-up.
//  Revision    : 1.0 - initial release
// ============================================================================
module interrupt_dispatch_sequencer #(
    parameter int          NUM_IRQ     = 5,
    parameter logic [15:0] VECTOR_BASE = 16'h0040,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic [NUM_IRQ-1:0] iInterruptFlag,
    input  logic [NUM_IRQ-1:0] iInterruptEnable,
    input  logic               iInstrBoundary,
    input  logic               iEI,
    input  logic               iDI,
    input  logic               iRETI,
    input  logic               iPushAck,
    output logic               oIME,
    output logic               oBusy,
    output logic               oPushReq,
    output logic               oPushHigh,
    output logic               oLoadPC,
    output logic [15:0]        oVector,
    output logic [NUM_IRQ-1:0] oClearFlag,
    output logic               oHaltWake
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [CW-1:0] C_WAIT_INIT = CW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_PUSH_HI = 3'd2,
        S_PUSH_LO = 3'd3,
        S_VECTOR  = 3'd4
    } state_t;

    state_t             r_state, n_state;
    logic [CW-1:0]      r_cnt, n_cnt;
    logic               r_ime, n_ime;
    logic               r_armed, n_armed;
    logic [IW-1:0]      r_index, n_index;
    logic               r_valid, n_valid;
    logic               r_push_req, n_push_req;
    logic               r_push_high, n_push_high;
    logic               r_load_pc, n_load_pc;
    logic [15:0]        r_vector, n_vector;
    logic [NUM_IRQ-1:0] r_clear, n_clear;

    logic [NUM_IRQ-1:0] w_pending;
    logic [IW-1:0]      w_index;
    logic               w_ime_eff;
    logic               w_accept;
    logic [15:0]        w_vector;
    logic [NUM_IRQ-1:0] w_onehot;

    assign w_pending = iInterruptFlag & iInterruptEnable;
    // An armed EI takes effect at the following boundary, so EI;NOP services after the NOP
    assign w_ime_eff = (r_ime | (r_armed & iInstrBoundary & ~iEI)) & ~iDI;
    assign w_accept  = (r_state == S_IDLE) & iInstrBoundary & w_ime_eff & (|w_pending);
    assign w_vector  = VECTOR_BASE + (16'(r_index) << 3);
    assign w_onehot  = NUM_IRQ'(1) << r_index;

    // Priority encoder: lowest set pending bit wins
    always_comb begin
        w_index = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pending[i]) w_index = IW'(i);
        end
    end

    // Next-state, IME bookkeeping and registered-output values
    always_comb begin
        n_state     = r_state;
        n_cnt       = r_cnt;
        n_ime       = r_ime;
        n_armed     = r_armed;
        n_index     = r_index;
        n_valid     = r_valid;
        n_push_req  = 1'b0;
        n_push_high = 1'b0;
        n_load_pc   = 1'b0;
        n_vector    = '0;
        n_clear     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    n_state = S_WAIT;
                    n_cnt   = C_WAIT_INIT;
                    n_ime   = 1'b0;
                    n_armed = 1'b0;
                end else if (iDI) begin
                    n_ime   = 1'b0;
                    n_armed = 1'b0;
                end else begin
                    if (iRETI) n_ime = 1'b1;
                    if (iEI) begin
                        n_armed = 1'b1;
                    end else if (r_armed && iInstrBoundary) begin
                        n_ime   = 1'b1;
                        n_armed = 1'b0;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    n_state     = S_PUSH_HI;
                    n_push_req  = 1'b1;
                    n_push_high = 1'b1;
                end else begin
                    n_cnt = r_cnt - 1'b1;
                end
            end
            S_PUSH_HI: begin
                n_push_req = 1'b1;
                if (iPushAck) begin
                    // IE/IF may have changed during the wait; the vector follows this sample
                    n_state = S_PUSH_LO;
                    n_index = w_index;
                    n_valid = |w_pending;
                end else begin
                    n_push_high = 1'b1;
                end
            end
            S_PUSH_LO: begin
                if (iPushAck) begin
                    n_state   = S_VECTOR;
                    n_load_pc = 1'b1;
                    n_vector  = r_valid ? w_vector : 16'h0000;
                    n_clear   = r_valid ? w_onehot : '0;
                end else begin
                    n_push_req = 1'b1;
                end
            end
            S_VECTOR: begin
                n_state = S_IDLE;
            end
            default: begin
                n_state = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge iClock) begin
        if (!iReset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ime       <= 1'b0;
            r_armed     <= 1'b0;
            r_index     <= '0;
            r_valid     <= 1'b0;
            r_push_req  <= 1'b0;
            r_push_high <= 1'b0;
            r_load_pc   <= 1'b0;
            r_vector    <= '0;
            r_clear     <= '0;
        end else begin
            r_state     <= n_state;
            r_cnt       <= n_cnt;
            r_ime       <= n_ime;
            r_armed     <= n_armed;
            r_index     <= n_index;
            r_valid     <= n_valid;
            r_push_req  <= n_push_req;
            r_push_high <= n_push_high;
            r_load_pc   <= n_load_pc;
            r_vector    <= n_vector;
            r_clear     <= n_clear;
        end
    end

    assign oIME       = r_ime;
    assign oBusy      = (r_state != S_IDLE);
    assign oPushReq   = r_push_req;
    assign oPushHigh  = r_push_high;
    assign oLoadPC    = r_load_pc;
    assign oVector    = r_vector;
    assign oClearFlag = r_clear;
    assign oHaltWake  = |w_pending;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_dispatch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_dispatch_sequencer
//  Description : Directed and randomized checks of the interrupt dispatch
//                sequencer against a rule-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_dispatch_sequencer;

    localparam int          NUM_IRQ     = 5;
    localparam int          WAIT_CYCLES = 2;
    localparam logic [15:0] VECTOR_BASE = 16'h0040;

    logic        iClock = 1'b0;
    logic        iReset;
    logic [4:0]  iInterruptFlag, iInterruptEnable;
    logic        iInstrBoundary, iEI, iDI, iRETI, iPushAck;
    logic        oIME, oBusy, oPushReq, oPushHigh, oLoadPC, oHaltWake;
    logic [15:0] oVector;
    logic [4:0]  oClearFlag;

    int checks   = 0;
    int failures = 0;
    bit m_ime, m_armed;

    interrupt_dispatch_sequencer #(
        .NUM_IRQ(NUM_IRQ), .VECTOR_BASE(VECTOR_BASE), .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .iClock(iClock), .iReset(iReset),
        .iInterruptFlag(iInterruptFlag), .iInterruptEnable(iInterruptEnable),
        .iInstrBoundary(iInstrBoundary), .iEI(iEI), .iDI(iDI), .iRETI(iRETI),
        .iPushAck(iPushAck), .oIME(oIME), .oBusy(oBusy), .oPushReq(oPushReq),
        .oPushHigh(oPushHigh), .oLoadPC(oLoadPC), .oVector(oVector),
        .oClearFlag(oClearFlag), .oHaltWake(oHaltWake)
    );

    always #5 iClock = ~iClock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    function automatic int lowest(input logic [4:0] p);
        for (int i = 0; i < NUM_IRQ; i++) if (p[i]) return i;
        return -1;
    endfunction

    // Strobes that the sequencer must ignore while a dispatch is running
    task automatic noise();
        iEI  = 1'($urandom_range(0, 1));
        iDI  = 1'($urandom_range(0, 1));
        iRETI = 1'($urandom_range(0, 1));
    endtask

    // One non-dispatch cycle; acc reports whether the model expects acceptance
    task automatic idle_cycle(input bit b, input bit ei, input bit di, input bit reti, output bit acc);
        logic [4:0] p;
        bit eff;
        iInstrBoundary = b; iEI = ei; iDI = di; iRETI = reti;
        p   = iInterruptFlag & iInterruptEnable;
        eff = (m_ime || (m_armed && b && !ei)) && !di;
        acc = b && eff && (p != 5'd0);
        #1 chk("haltwake", oHaltWake, |p);
        if (acc || di) begin
            m_ime = 1'b0; m_armed = 1'b0;
        end else begin
            if (reti) m_ime = 1'b1;
            if (ei) m_armed = 1'b1;
            else if (m_armed && b) begin m_ime = 1'b1; m_armed = 1'b0; end
        end
        step();
        iInstrBoundary = 0; iEI = 0; iDI = 0; iRETI = 0;
        chk("ime", oIME, m_ime);
        chk("busy_after_boundary", oBusy, acc);
        chk("no_early_req", oPushReq, 0);
    endtask

    // Dispatch sequence following an accept edge
    task automatic run_dispatch(input int hi_d, input int lo_d, input bit poke,
                                input logic [4:0] poke_ie, input bit abort);
        logic [4:0]  p;
        int          idx;
        logic [15:0] ev;
        logic [4:0]  ec;
        for (int k = 1; k < WAIT_CYCLES; k++) begin
            noise(); step();
            chk("wait_noreq", oPushReq, 0);
            chk("wait_busy", oBusy, 1);
        end
        noise(); step();
        chk("hi_req", oPushReq, 1);
        chk("hi_high", oPushHigh, 1);
        for (int k = 0; k < hi_d; k++) begin
            noise(); step();
            chk("hi_hold_req", oPushReq, 1);
            chk("hi_hold_high", oPushHigh, 1);
            chk("hi_no_load", oLoadPC, 0);
        end
        if (poke) iInterruptEnable = poke_ie;
        iPushAck = 1'b1;
        p = iInterruptFlag & iInterruptEnable;
        step();
        iPushAck = 1'b0;
        chk("lo_req", oPushReq, 1);
        chk("lo_high", oPushHigh, 0);
        if (abort) begin
            iReset = 1'b0; iInterruptFlag = 5'b10000; iInterruptEnable = 5'b10000;
            step();
            iReset = 1'b1;
            m_ime = 1'b0; m_armed = 1'b0;
            chk("rst_ime", oIME, 0);
            chk("rst_busy", oBusy, 0);
            chk("rst_req", oPushReq, 0);
            chk("rst_high", oPushHigh, 0);
            chk("rst_load", oLoadPC, 0);
            chk("rst_vector", oVector, 0);
            chk("rst_clear", oClearFlag, 0);
            chk("rst_haltwake", oHaltWake, 1);
            iEI = 0; iDI = 0; iRETI = 0;
            return;
        end
        for (int k = 0; k < lo_d; k++) begin
            noise(); step();
            chk("lo_hold_req", oPushReq, 1);
            chk("lo_hold_high", oPushHigh, 0);
            chk("lo_no_load", oLoadPC, 0);
        end
        iPushAck = 1'b1;
        step();
        iPushAck = 1'b0;
        idx = lowest(p);
        ev  = (idx < 0) ? 16'h0000 : VECTOR_BASE + 16'(8 * idx);
        ec  = (idx < 0) ? 5'd0 : 5'(1 << idx);
        chk("vec_load", oLoadPC, 1);
        chk("vec_vector", oVector, ev);
        chk("vec_clear", oClearFlag, ec);
        chk("vec_busy", oBusy, 1);
        chk("vec_noreq", oPushReq, 0);
        step();
        iEI = 0; iDI = 0; iRETI = 0;
        chk("end_load", oLoadPC, 0);
        chk("end_busy", oBusy, 0);
        chk("end_clear", oClearFlag, 0);
        chk("end_ime", oIME, m_ime);
        if (idx >= 0) iInterruptFlag[idx] = 1'b0;
    endtask

    initial begin
        bit acc;
        iReset = 0; iInterruptFlag = 0; iInterruptEnable = 0;
        iInstrBoundary = 0; iEI = 0; iDI = 0; iRETI = 0; iPushAck = 0;
        m_ime = 0; m_armed = 0;
        step(); step();
        chk("reset_ime", oIME, 0);
        chk("reset_busy", oBusy, 0);
        chk("reset_req", oPushReq, 0);
        chk("reset_high", oPushHigh, 0);
        chk("reset_load", oLoadPC, 0);
        chk("reset_vector", oVector, 0);
        chk("reset_clear", oClearFlag, 0);
        iReset = 1;

        // RETI then dispatch with IF=00110: vector 0x48
        iInterruptFlag = 5'b00110; iInterruptEnable = 5'h1F;
        idle_cycle(0, 0, 0, 1, acc);
        idle_cycle(1, 0, 0, 0, acc);
        chk("t1_accept", acc, 1);
        if (acc) run_dispatch(0, 0, 0, 5'd0, 0);

        // EI at boundary, NOP boundary dispatches
        iInterruptFlag = 5'b00001; iInterruptEnable = 5'b00001;
        idle_cycle(1, 1, 0, 0, acc);
        chk("t2_no_accept_at_ei", acc, 0);
        idle_cycle(1, 0, 0, 0, acc);
        chk("t2_accept_at_nop", acc, 1);
        if (acc) run_dispatch(1, 2, 0, 5'd0, 0);

        // EI and DI together: IME never rises
        iInterruptFlag = 5'b01000; iInterruptEnable = 5'h1F;
        idle_cycle(1, 1, 1, 0, acc);
        for (int k = 0; k < 3; k++) idle_cycle(1, 0, 0, 0, acc);

        // IE cleared during PUSH_HI: null vector
        idle_cycle(0, 0, 0, 1, acc);
        idle_cycle(1, 0, 0, 0, acc);
        if (acc) run_dispatch(2, 0, 1, 5'd0, 0);
        iInterruptEnable = 5'h1F;

        // Long PUSH_LO ack wait
        idle_cycle(0, 0, 0, 1, acc);
        idle_cycle(1, 0, 0, 0, acc);
        if (acc) run_dispatch(0, 10, 0, 5'd0, 0);

        // Reset in PUSH_LO
        iInterruptFlag = 5'b00100;
        idle_cycle(0, 0, 0, 1, acc);
        idle_cycle(1, 0, 0, 0, acc);
        if (acc) run_dispatch(0, 0, 0, 5'd0, 1);
        idle_cycle(1, 0, 0, 0, acc);
        chk("t6_no_dispatch", acc, 0);

        // Randomized scenarios
        for (int it = 0; it < 40; it++) begin
            iInterruptFlag   = 5'($urandom);
            iInterruptEnable = 5'($urandom);
            for (int c = 0; c < 4; c++) begin
                idle_cycle(1'($urandom_range(0, 1)),
                           ($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 5) == 0),
                           ($urandom_range(0, 3) == 0), acc);
                if (acc) begin
                    run_dispatch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                 ($urandom_range(0, 3) == 0), 5'($urandom), 0);
                    break;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
